// File: rtl/md_scheduler.sv
// Multiply/divide sequencer for the pipelined MIPS core: fixed-latency busy
// countdown, HI/LO commit, D-stage stall and HI/LO read-back select.
module md_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use_d,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        stall
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic [1:0]      op_q, op_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;

  logic [63:0]     prod;
  logic            sgn, a_neg, b_neg;
  logic [31:0]     a_mag, b_mag, uq, ur, quo, rem;

  // Division runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000
  // instead of hitting a signed-overflow corner in the divider.
  always_comb begin
    sgn   = ~op_q[0];
    prod  = sgn ? ({{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q})
                : ({32'b0, a_q} * {32'b0, b_q});
    a_neg = sgn & a_q[31];
    b_neg = sgn & b_q[31];
    a_mag = a_neg ? (32'd0 - a_q) : a_q;
    b_mag = b_neg ? (32'd0 - b_q) : b_q;
    uq    = '0;
    ur    = '0;
    if (b_mag != '0) begin
      uq = a_mag / b_mag;
      ur = a_mag % b_mag;
    end
    quo = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    rem = a_neg ? (32'd0 - ur) : ur;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              a_d     = a;
              b_d     = b;
              op_d    = op[1:0];
              state_d = BUSY;
              count_d = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end
            3'd4:    hi_d = a;
            3'd5:    lo_d = a;
            default: ;
          endcase
        end
      end
      BUSY: begin
        count_d = count_q - 1'b1;
        if (count_q == CW'(1)) begin
          state_d = IDLE;
          if (!op_q[1]) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (b_q != '0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    hi      = hi_q;
    lo      = lo_q;
    busy    = (state_q == BUSY);
    stall   = md_use_d & (busy | (start & (op <= 3'd3)));
    rd_data = (op == 3'd6) ? hi_q : (op == 3'd7) ? lo_q : '0;
  end

endmodule

// File: tb/tb_md_scheduler.sv
// Directed self-checking bench for md_scheduler with hand-computed HI/LO values.
module tb_md_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        md_use_d;
  logic [31:0] hi, lo, rd_data;
  logic        busy, stall;

  int checks = 0;
  int errors = 0;

  md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .md_use_d(md_use_d), .hi(hi), .lo(lo), .rd_data(rd_data),
    .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; md_use_d = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);

    // mult -1 * 2 with mflo waiting in D
    md_use_d = 1'b1; start = 1'b1; op = 3'd0; a = 32'hFFFF_FFFF; b = 32'd2;
    #1 check("mult_start_stall", 32'(stall), 32'h1);
    tick();
    start = 1'b0; op = 3'd7;
    for (int i = 0; i < 5; i++) begin
      check("mult_busy", 32'(busy), 32'h1);
      check("mult_stall", 32'(stall), 32'h1);
      check("mult_lo_hold", lo, 32'h0);
      tick();
    end
    check("mult_busy_done", 32'(busy), 32'h0);
    check("mult_stall_done", 32'(stall), 32'h0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);
    check("mflo_rd", rd_data, 32'hFFFF_FFFE);
    op = 3'd6;
    #1 check("mfhi_rd", rd_data, 32'hFFFF_FFFF);
    op = 3'd1;
    #1 check("rd_other", rd_data, 32'h0);

    // multu 0xFFFFFFFF * 2
    start = 1'b1; op = 3'd1; a = 32'hFFFF_FFFF; b = 32'd2;
    tick();
    start = 1'b0; op = 3'd7;
    for (int i = 0; i < 4; i++) tick();
    check("multu_busy_last", 32'(busy), 32'h1);
    tick();
    check("multu_busy_done", 32'(busy), 32'h0);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    // div -7 / 2
    start = 1'b1; op = 3'd2; a = 32'hFFFF_FFF9; b = 32'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("div_busy_last", 32'(busy), 32'h1);
    check("div_lo_hold", lo, 32'hFFFF_FFFE);
    tick();
    check("div_busy_done", 32'(busy), 32'h0);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // divu 7 / 0 leaves HI/LO alone but still runs the full latency
    start = 1'b1; op = 3'd3; a = 32'd7; b = 32'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("div0_busy_last", 32'(busy), 32'h1);
    tick();
    check("div0_busy_done", 32'(busy), 32'h0);
    check("div0_lo", lo, 32'hFFFF_FFFD);
    check("div0_hi", hi, 32'hFFFF_FFFF);

    // overflow case 0x80000000 / -1
    start = 1'b1; op = 3'd2; a = 32'h8000_0000; b = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'h0);

    // mthi then mtlo back to back
    start = 1'b1; op = 3'd4; a = 32'h1234_5678;
    #1 check("mthi_stall", 32'(stall), 32'h0);
    tick();
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_busy", 32'(busy), 32'h0);
    op = 3'd5; a = 32'h9ABC_DEF0;
    #1 check("mtlo_stall", 32'(stall), 32'h0);
    tick();
    start = 1'b0;
    check("mtlo_lo", lo, 32'h9ABC_DEF0);
    check("mtlo_hi_keep", hi, 32'h1234_5678);
    check("mtlo_busy", 32'(busy), 32'h0);

    // div 100 / 7 with non-MD in D, plus a start mid-busy that must be ignored
    md_use_d = 1'b0;
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    #1 check("nomd_start_stall", 32'(stall), 32'h0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 3) begin
        start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
      end else begin
        start = 1'b0;
      end
      #1 check("nomd_stall", 32'(stall), 32'h0);
      tick();
    end
    start = 1'b0;
    check("ign_busy_last", 32'(busy), 32'h1);
    tick();
    check("ign_busy_done", 32'(busy), 32'h0);
    check("ign_lo", lo, 32'd14);
    check("ign_hi", hi, 32'd2);

    // reset in the middle of a mult aborts it without commit
    md_use_d = 1'b1;
    start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd3;
    tick();
    start = 1'b0; op = 3'd7;
    tick(); tick();
    reset = 1'b1;
    #1;
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_stall", 32'(stall), 32'h0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("midrst_lo_after", lo, 32'h0);
    check("midrst_busy_after", 32'(busy), 32'h0);
    check("midrst_stall_after", 32'(stall), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_scheduler.md
Name: md_scheduler

Overview:
Sequences the shared multiply/divide resource of the pipelined MIPS core. It accepts an MD operation from the EX stage and runs a fixed-latency busy countdown. It commits results into the HI/LO registers and raises a stall toward the D stage while any MD-dependent instruction must wait. It also drives the HI/LO read selection returned to the EX-stage result mux.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  EX-stage MD instruction valid this cycle
op  input  3  0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo 6=mfhi 7=mflo
a  input  32  rs operand (EX, already forwarded)
b  input  32  rt operand (EX, already forwarded)
md_use_d  input  1  D-stage instruction is any MD op (mult..mflo)
hi  output  32  HI register
lo  output  32  LO register
rd_data  output  32  hi when op==6, lo when op==7, else 0 (combinational)
busy  output  1  countdown in progress
stall  output  1  freeze PC/IF-ID, bubble ID-EX

Behaviour:
- Reset: hi=0, lo=0, busy=0, count=0, state IDLE. Reset mid-operation aborts it; nothing is committed.
- States:
  - IDLE: no operation in progress.
  - BUSY: count>0.
- IDLE, start with op 0-3:
  - latch a, b, op at the edge.
  - enter BUSY with count=MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3).
  - busy=1 from the next cycle.
- BUSY: count decrements each edge.
  - On the edge where count goes 1->0, commit hi/lo and return to IDLE.
  - busy drops in the same cycle hi/lo show the new values.
  - Total: start at edge N; results visible after edge N+CYCLES.
- Arithmetic:
  - mult: signed 32x32->64, {hi,lo}=product.
  - multu: unsigned 32x32->64, {hi,lo}=product.
  - div: signed; lo=quotient, hi=remainder, remainder sign follows dividend, truncation toward zero.
  - divu: unsigned; lo=quotient, hi=remainder.
  - Divisor 0 (div/divu): hi/lo unchanged; busy still runs the full DIV_CYCLES.
  - 0x80000000 / -1 (div): lo=0x80000000, hi=0.
- mthi/mtlo (op 4/5) with start in IDLE: hi (or lo) = a at the next edge, no busy.
- mfhi/mflo: rd_data reflects current hi/lo combinationally. No state change.
- start while busy=1: ignored, no state change. The stall guarantees this cannot occur legally.
- stall = md_use_d & (busy | (start & op<=3)).
  - Stall covers the start cycle itself.
  - Stall is deasserted in the commit cycle+1, i.e. the first cycle with busy=0.
- Non-MD instructions in D never stall.
- Any MD instruction in D stalls while busy, including a second mult and mfhi.

Test Plan:
1. reset high mid-run, then low -> hi=lo=0, busy=0, stall=0. A mult started before reset never commits.
2. mult a=0xFFFFFFFF b=2, start 1 cycle; md_use_d=1 throughout (mflo in D) -> busy high for exactly 5 cycles, stall high 6 cycles (start cycle + busy). Then hi=0xFFFFFFFF, lo=0xFFFFFFFE; with op=7, rd_data=0xFFFFFFFE.
3. multu a=0xFFFFFFFF b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
4. div a=-7 (0xFFFFFFF9) b=2 -> busy 10 cycles. Then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu a=7 b=0 -> hi/lo unchanged after 10 busy cycles.
5. mthi a=0x12345678 then mtlo a=0x9ABCDEF0 on consecutive cycles -> hi/lo updated on each following edge, busy stays 0, stall stays 0.
6. div start with md_use_d=0 (add in D) -> stall=0 throughout. Second start asserted mid-busy -> ignored, count and result unaffected.
